// File: rtl/dm_store_ctrl.sv
// Store controller for a word-wide data memory without byte enables: sw writes directly, sb/sh use read-modify-write.
// Optional store address-error detection is enabled by defining DM_ADES_EN.
module dm_store_ctrl #(
  parameter int unsigned DM_AW = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [5:0]       opcode,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata_in,
  output logic             stall,
  output logic             done,
  output logic [DM_AW-1:0] dm_addr,
  output logic             dm_re,
  input  logic [31:0]      dm_rdata,
  output logic             dm_we,
  output logic [31:0]      dm_wdata,
  output logic             ades
);

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [1:0] {IDLE, WRITE, READ, MERGE} state_t;

  state_t           state_q, state_d;
  logic [5:0]       op_q;
  logic [DM_AW+1:0] addr_q;
  logic [31:0]      wdata_q;
  logic             is_store;
  logic             misalign;
  logic [31:0]      merged;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^addr[31:DM_AW+2];

  always_comb begin
    is_store = st_valid & ((opcode == OP_SB) | (opcode == OP_SH) | (opcode == OP_SW));
`ifdef DM_ADES_EN
    misalign = ((opcode == OP_SH) & addr[0]) | ((opcode == OP_SW) & (addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && is_store && !misalign) begin
        op_q    <= opcode;
        addr_q  <= addr[DM_AW+1:0];
        wdata_q <= wdata_in;
      end
    end
  end

  // Lane merge uses the latched low address bits; dm_rdata holds the old word in MERGE.
  always_comb begin
    merged = dm_rdata;
    if (op_q == OP_SB) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    dm_re    = 1'b0;
    dm_we    = 1'b0;
    dm_wdata = '0;
    done     = 1'b0;
    ades     = 1'b0;
    dm_addr  = addr_q[DM_AW+1:2];
    unique case (state_q)
      IDLE: begin
        dm_addr = '0;
        if (is_store) begin
          if (misalign) begin
            ades = 1'b1;
            done = 1'b1;
          end else if (opcode == OP_SW) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        dm_we    = 1'b1;
        dm_wdata = wdata_q;
        done     = 1'b1;
        state_d  = IDLE;
      end
      READ: begin
        dm_re   = 1'b1;
        state_d = MERGE;
      end
      MERGE: begin
        dm_we    = 1'b1;
        dm_wdata = merged;
        done     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Strobes are suppressed while reset is held so an aborted sequence never touches DM.
    if (reset) begin
      dm_re = 1'b0;
      dm_we = 1'b0;
      done  = 1'b0;
      ades  = 1'b0;
    end
    stall = is_store & ~done;
  end

endmodule

// File: tb/tb_dm_store_ctrl.sv
// Directed self-checking bench for dm_store_ctrl with a simple synchronous-read word memory.
module tb_dm_store_ctrl;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_LW = 6'b100011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata_in = '0;
  logic        stall, done, dm_re, dm_we, ades;
  logic [11:0] dm_addr;
  logic [31:0] dm_rdata, dm_wdata;

  logic [31:0] mem [0:4095];
  logic [31:0] rd_q = '0;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  dm_store_ctrl #(.DM_AW(12)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .opcode(opcode),
    .addr(addr), .wdata_in(wdata_in), .stall(stall), .done(done),
    .dm_addr(dm_addr), .dm_re(dm_re), .dm_rdata(dm_rdata), .dm_we(dm_we),
    .dm_wdata(dm_wdata), .ades(ades)
  );

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_wdata;
    if (dm_re) rd_q <= mem[dm_addr];
  end
  assign dm_rdata = rd_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive new inputs just after the rising edge, return at the falling edge for sampling.
  task automatic put(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    st_valid = v;
    opcode   = op;
    addr     = a;
    wdata_in = d;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_rmw(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp);
    put(1'b1, op, a, d);
    check({tag, " acc stall"}, stall, 1);
    check({tag, " acc re"}, dm_re, 0);
    tick();
    check({tag, " rd re"}, dm_re, 1);
    check({tag, " rd addr"}, dm_addr, 4);
    check({tag, " rd done"}, done, 0);
    tick();
    check({tag, " mg we"}, dm_we, 1);
    check({tag, " mg wdata"}, dm_wdata, exp);
    check({tag, " mg done"}, done, 1);
    check({tag, " mg stall"}, stall, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    @(negedge clk);
    check("rst stall", stall, 0);
    check("rst done", done, 0);
    check("rst we", dm_we, 0);
    check("rst re", dm_re, 0);
    check("rst ades", ades, 0);
    check("rst addr", dm_addr, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post rst done", done, 0);

    // sw latency and outputs
    put(1'b1, OP_SW, 32'h0000_0010, 32'hDEADBEEF);
    check("sw c1 stall", stall, 1);
    check("sw c1 done", done, 0);
    check("sw c1 we", dm_we, 0);
    tick();
    check("sw c2 we", dm_we, 1);
    check("sw c2 addr", dm_addr, 4);
    check("sw c2 wdata", dm_wdata, 32'hDEADBEEF);
    check("sw c2 done", done, 1);
    check("sw c2 stall", stall, 0);
    put(1'b0, '0, '0, '0);
    check("sw mem", mem[4], 32'hDEADBEEF);
    check("sw idle we", dm_we, 0);

    // sw then back-to-back sb reading the just-written word; inputs change during READ
    put(1'b1, OP_SW, 32'h0000_0010, 32'h11223344);
    tick();
    check("b2b sw we", dm_we, 1);
    put(1'b1, OP_SB, 32'h0000_0012, 32'h0000_00AB);
    check("b2b sb acc stall", stall, 1);
    check("b2b sb acc we", dm_we, 0);
    put(1'b1, OP_SB, 32'h0000_0013, 32'h0000_00CC);
    check("b2b sb rd re", dm_re, 1);
    check("b2b sb rd addr", dm_addr, 4);
    check("b2b sb rd we", dm_we, 0);
    tick();
    check("b2b sb mg we", dm_we, 1);
    check("b2b sb mg wdata", dm_wdata, 32'h11AB3344);
    check("b2b sb mg done", done, 1);

    do_rmw("sh hi", OP_SH, 32'h0000_0012, 32'hFFFF5566, 32'h55663344);
    do_rmw("sh lo", OP_SH, 32'h0000_0010, 32'h00005566, 32'h55665566);
    do_rmw("sb l3", OP_SB, 32'h0000_0013, 32'h00000077, 32'h77665566);
    do_rmw("sb l0", OP_SB, 32'h0000_0010, 32'h00000099, 32'h77665599);
    put(1'b0, '0, '0, '0);
    check("rmw mem", mem[4], 32'h77665599);

    // non-store opcode
    put(1'b1, OP_LW, 32'h0000_0010, '0);
    check("lw stall", stall, 0);
    check("lw re", dm_re, 0);
    tick();
    check("lw we", dm_we, 0);
    check("lw done", done, 0);

    // reset while in READ of an sb
    put(1'b1, OP_SB, 32'h0000_0010, 32'h0000005A);
    check("abort acc stall", stall, 1);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    st_valid = 1'b0;
    @(negedge clk);
    check("abort rst we", dm_we, 0);
    check("abort rst done", done, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      check("abort we", dm_we, 0);
      check("abort stall", stall, 0);
      tick();
    end
    check("abort mem", mem[4], 32'h77665599);

    // misaligned stores
    put(1'b1, OP_SW, 32'h0000_0013, 32'hCAFEF00D);
`ifdef DM_ADES_EN
    check("mis sw ades", ades, 1);
    check("mis sw done", done, 1);
    check("mis sw stall", stall, 0);
    check("mis sw we", dm_we, 0);
    check("mis sw re", dm_re, 0);
    put(1'b1, OP_SH, 32'h0000_0011, 32'h00001234);
    check("mis sh ades", ades, 1);
    check("mis sh done", done, 1);
    put(1'b0, '0, '0, '0);
    check("mis idle ades", ades, 0);
    check("mis idle we", dm_we, 0);
    tick();
    check("mis mem", mem[4], 32'h77665599);
`else
    check("mis sw stall", stall, 1);
    check("mis sw ades", ades, 0);
    tick();
    check("mis sw we", dm_we, 1);
    check("mis sw addr", dm_addr, 4);
    check("mis sw wdata", dm_wdata, 32'hCAFEF00D);
    put(1'b0, '0, '0, '0);
    check("mis mem", mem[4], 32'hCAFEF00D);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/dm_store_ctrl.md
Name: dm_store_ctrl

Overview:
- Store-side counterpart of the MEM-stage load extender: handles sb/sh/sw into a word-wide data memory that has no byte enables.
- sw is written directly.
- sb/sh use a read-modify-write sequence: read the word, merge the lane, write back.
- Sits between MEM-stage pipeline registers and DM; stalls the pipeline until the store has committed.

Parameters:
- DM_AW, 12, DM word-address width; dm_addr = addr[DM_AW+1:2].

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- st_valid  input  1  MEM stage holds a memory instruction; held stable until done
- opcode  input  6  instruction opcode; sb=6'b101000, sh=6'b101001, sw=6'b101011
- addr  input  32  byte address (ALU result)
- wdata_in  input  32  forwarded rt value
- stall  output  1  freeze IF/ID/EX/MEM while a store is in progress
- done  output  1  one-cycle pulse, store committed this cycle
- dm_addr  output  DM_AW  word address to DM
- dm_re  output  1  DM read strobe; synchronous read, data valid next cycle
- dm_rdata  input  32  DM read data
- dm_we  output  1  DM write strobe
- dm_wdata  output  32  DM write data
- ades  output  1  store address-error pulse (see Optional Feature)

Behaviour:
- is_store = st_valid & opcode in {sb, sh, sw}. Any other opcode: no DM access, no stall, no done.
- States: IDLE, WRITE, READ, MERGE. Reset value: IDLE.
- Request latch: in IDLE with is_store, latch opcode, addr, wdata_in.
  - sw goes to WRITE.
  - sb/sh go to READ.
- WRITE:
  - dm_we=1, dm_wdata=latched wdata, done=1.
  - Next state IDLE.
  - sw latency: 2 cycles from presentation, done in the 2nd.
- READ: dm_re=1, dm_addr=latched word address. Next state MERGE.
- MERGE (dm_rdata valid):
  - dm_we=1; dm_wdata = dm_rdata with the selected lane replaced; done=1.
  - Next state IDLE.
  - sb/sh latency: 3 cycles.
- Lane merge:
  - sb: lane k=addr[1:0]; bits [8k+7:8k] = wdata[7:0]; other bytes unchanged.
  - sh: addr[1]=0 replaces [15:0], addr[1]=1 replaces [31:16], with wdata[15:0].
- dm_addr is driven from the latched address in WRITE/READ/MERGE; 0 in IDLE.
- stall = is_store & ~done. It is combinational, so it is high in the acceptance cycle and low in the done cycle; the pipeline advances on the done edge.
- Back-to-back stores: a new store presented the cycle after done is accepted in IDLE with no bubble beyond normal latency.
- dm_re, dm_we, done, ades are 0 whenever not stated otherwise, and 0 during and immediately after reset.
- Reset mid-operation (any non-IDLE state): sequence aborted, no dm_we issued, state IDLE next cycle; the DM word is left untouched.
- The latched request is never updated outside IDLE; changes on inputs during a sequence are ignored.

Optional Feature:
- Macro: DM_ADES_EN.
- Defined:
  - Misaligned sh (addr[0]=1) or sw (addr[1:0]!=0) is detected in IDLE.
  - No DM access; ades=1 and done=1 for one cycle (acceptance cycle); stall=0 that cycle; state stays IDLE.
  - sb is never misaligned.
- Undefined:
  - ades tied 0.
  - sh ignores addr[0]; sw ignores addr[1:0]; both proceed normally.

Test Plan:
- Reset then sw: addr=0x0000_0010, wdata=0xDEADBEEF -> cycle 1 stall=1; cycle 2 dm_we=1, dm_addr=4, dm_wdata=0xDEADBEEF, done=1, stall=0.
- sb: DM word 4 = 0x11223344, addr=0x12, wdata=0x000000AB -> READ dm_re=1 dm_addr=4; MERGE dm_wdata=0x11AB3344, done=1; total 3 cycles.
- sh: same word, addr=0x12, wdata=0xFFFF5566 -> merged 0x55663344; then sh at addr=0x10 -> 0x55665566.
- Back-to-back: sw followed immediately by sb to the same word -> sb reads the value just written; merge is correct; no lost or duplicated dm_we.
- Reset asserted in READ state of an sb -> no dm_we in any following cycle; state IDLE; stall low once st_valid drops.
- With DM_ADES_EN: sw at addr=0x13 -> ades=1, done=1 in the same cycle, dm_we=0, dm_re=0. Without the macro, the same stimulus writes word 4.
